// File: rtl/prbs_checker_if.sv
// Stream and status bundle between a PRBS source (master) and prbs_checker (slave).
// The bit_cnt member exists only when PRBS_CHECKER_BITCNT_EN is defined.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );

    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );
`else
    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_cnt
    );

    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_cnt
    );
`endif
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising Fibonacci-LFSR PRBS checker with lock tracking and a saturating error count.
// Optional macro PRBS_CHECKER_BITCNT_EN adds a saturating count of bits received while locked.
module prbs_checker #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] TAPS     = 5'b10100,
    parameter int               LOCK_CNT = 8,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic lfsr_pred(input logic [WIDTH-1:0] s);
        return ^(s & TAPS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
`endif

    logic pred;
    logic hit;

    // An all-zero register would predict zeros forever, so it never counts as a match.
    assign pred = lfsr_pred(sr_q);
    assign hit  = (bus.in_bit == pred) && (sr_q != '0);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
        bit_cnt_d   = bit_cnt_q;
`endif

        if (bus.in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    sr_d   = {sr_q[WIDTH-2:0], bus.in_bit};
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                    end
                end

                ST_VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.in_bit};
                    if (hit) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                ST_LOCKED: begin
                    // Flywheel: the register follows its own prediction, so line errors cannot corrupt it.
                    sr_d = {sr_q[WIDTH-2:0], pred};
`ifdef PRBS_CHECKER_BITCNT_EN
                    bit_cnt_d = sat_inc(bit_cnt_q);
`endif
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d = ST_SEARCH;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_SEARCH;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear takes priority over a same-cycle increment; the error strobe is left alone.
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
    assign bus.bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: table-driven lock/error/loss vectors plus hand-written
// sequences for counter saturation, clear priority, mid-cycle reset, valid gaps and a zero stream.
module tb_prbs_checker;

    localparam logic [4:0] TAPS = 5'b10100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(16)) bus  ();
    prbs_checker_if #(.CNT_W(2))  bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_bit   = bus.in_bit;
    assign bus2.clr_cnt  = bus.clr_cnt;

    prbs_checker #(.WIDTH(5), .TAPS(TAPS), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prbs_checker #(.WIDTH(5), .TAPS(TAPS), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic        v;
        logic        flip;
        logic        clr;
        logic        exp_lock;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] gen_sr;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic flip, input logic clr,
                       input logic l, input logic p, input logic [15:0] c);
        vec_t e;
        e.v = v; e.flip = flip; e.clr = clr;
        e.exp_lock = l; e.exp_pulse = p; e.exp_cnt = c;
        tbl.push_back(e);
    endtask

    task automatic drive_raw(input logic v, input logic b, input logic clr);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.clr_cnt  = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr_cnt  = 1'b0;
    endtask

    // Reference generator: emits ^(sr & TAPS) and shifts it in; flip corrupts the line bit only.
    task automatic drive(input logic v, input logic flip, input logic clr);
        logic b;
        b = 1'b0;
        if (v) begin
            b      = ^(gen_sr & TAPS);
            gen_sr = {gen_sr[3:0], b};
        end
        drive_raw(v, b ^ flip, clr);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_seen;
        logic v;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.clr_cnt  = 1'b0;
        gen_sr       = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked",     32'(bus.locked),     32'd0);
        chk("rst_err_pulse",  32'(bus.err_pulse),  32'd0);
        chk("rst_err_cnt",    32'(bus.err_cnt),    32'd0);
        chk("rst_err_cnt_w2", 32'(bus2.err_cnt),   32'd0);
        rst = 1'b0;

        // Clean lock at the 13th valid bit, then 100 clean bits.
        for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) add(1, 0, 0, 1, 0, 0);
        // Single error, idle gap, then flywheel keeps matching.
        add(1, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 0, 1);
        add(1, 0, 1, 1, 0, 0);
        // Four consecutive errors drop lock on the fourth, which is still counted.
        add(1, 1, 0, 1, 1, 1);
        add(1, 1, 0, 1, 1, 2);
        add(1, 1, 0, 1, 1, 3);
        add(1, 1, 0, 0, 1, 4);
        for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 0, 4);
        add(1, 0, 0, 1, 0, 4);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 0, 4);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].flip, tbl[i].clr);
            chk($sformatf("vec%0d_locked", i),    32'(bus.locked),    32'(tbl[i].exp_lock));
            chk($sformatf("vec%0d_err_pulse", i), 32'(bus.err_pulse), 32'(tbl[i].exp_pulse));
            chk($sformatf("vec%0d_err_cnt", i),   32'(bus.err_cnt),   32'(tbl[i].exp_cnt));
        end

        // Saturation on the 2-bit counter with isolated errors.
        drive(1, 0, 1);
        chk("clr_w2", 32'(bus2.err_cnt), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 0);
            chk($sformatf("sat%0d_err_cnt_w2", k), 32'(bus2.err_cnt), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat%0d_pulse_w2", k),   32'(bus2.err_pulse), 32'd1);
            chk($sformatf("sat%0d_locked_w2", k),  32'(bus2.locked),    32'd1);
            repeat (3) drive(1, 0, 0);
        end
        chk("sat_err_cnt_w16", 32'(bus.err_cnt), 32'd5);

        // Clear coinciding with an error: count clears, strobe still fires.
        drive(1, 1, 1);
        chk("clr_err_cnt_w2",   32'(bus2.err_cnt),   32'd0);
        chk("clr_err_pulse_w2", 32'(bus2.err_pulse), 32'd1);
        chk("clr_err_cnt_w16",  32'(bus.err_cnt),    32'd0);
        chk("clr_locked",       32'(bus.locked),     32'd1);
        drive(1, 0, 0);

        // Asynchronous reset between edges while locked with a live error.
        drive(1, 1, 0);
        chk("pre_rst_err_cnt", 32'(bus.err_cnt),   32'd1);
        chk("pre_rst_pulse",   32'(bus.err_pulse), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked",  32'(bus.locked),    32'd0);
        chk("async_rst_err_cnt", 32'(bus.err_cnt),   32'd0);
        chk("async_rst_pulse",   32'(bus.err_pulse), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock with in_valid toggling: lock still lands on the 13th valid bit.
        gen_sr     = 5'b11111;
        valid_seen = 0;
        for (int i = 0; i < 26; i++) begin
            v = (i % 2 == 0);
            drive(v, 0, 0);
            if (v) valid_seen++;
            chk($sformatf("gap%0d_locked", i), 32'(bus.locked), (valid_seen >= 13) ? 32'd1 : 32'd0);
        end

        // Constant-zero stream never locks and never counts.
        pulse_reset();
        for (int i = 0; i < 200; i++) begin
            drive_raw(1'b1, 1'b0, 1'b0);
            if (bus.locked !== 1'b0) chk($sformatf("zero%0d_locked", i), 32'(bus.locked), 32'd0);
        end
        chk("zero_locked",    32'(bus.locked),    32'd0);
        chk("zero_err_cnt",   32'(bus.err_cnt),   32'd0);
        chk("zero_err_pulse", 32'(bus.err_pulse), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
